// File: rtl/ad7928_pkg.sv
// AD7928 scheduler shared types and constants.
// Control-word layout, state encoding and frame tag bundle.
package ad7928_pkg;

  localparam int B_WRITE  = 15;
  localparam int B_SEQ    = 14;
  localparam int B_ADD    = 10;
  localparam int B_PM     = 8;
  localparam int B_SHADOW = 7;
  localparam int B_RANGE  = 5;
  localparam int B_CODING = 4;

  localparam logic [1:0]  PM_NORMAL  = 2'b11;
  localparam logic [15:0] DUMMY_WORD = 16'hFFFF;
  localparam logic [15:0] FLUSH_WORD = 16'h0000;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_WAIT,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_IDLE
  } state_e;

  typedef struct packed {
    logic       vld;
    logic [2:0] ch;
    logic       oneshot;
  } tag_t;

  function automatic logic [15:0] ctrl_word(
    input logic [2:0] ch,
    input logic       range,
    input logic       coding
  );
    logic [15:0] w;
    w              = '0;
    w[B_WRITE]     = 1'b1;
    w[B_SEQ]       = 1'b0;
    w[B_ADD+:3]    = ch;
    w[B_PM+:2]     = PM_NORMAL;
    w[B_SHADOW]    = 1'b0;
    w[B_RANGE]     = range;
    w[B_CODING]    = coding;
    return w;
  endfunction

endpackage

// File: rtl/ad7928_rr_pick.sv
// Round-robin picker: first set mask bit strictly after ptr_i,
// wrapping 7 to 0 (ptr_i itself is checked last).
module ad7928_rr_pick (
  input  logic [7:0] mask_i,
  input  logic [2:0] ptr_i,
  output logic       found_o,
  output logic [2:0] sel_o
);

  always_comb begin
    found_o = 1'b0;
    sel_o   = ptr_i;
    for (int i = 1; i <= 8; i++) begin
      if (!found_o && mask_i[ptr_i + 3'(i)]) begin
        found_o = 1'b1;
        sel_o   = ptr_i + 3'(i);
      end
    end
  end

endmodule

// File: rtl/ad7928_sched.sv
// AD7928 conversion scheduler: round-robin scan with one-shot
// preemption, power-up dummies and one-frame result re-alignment.
module ad7928_sched
  import ad7928_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 50,
  parameter int PWRUP_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_en,
  input  logic [7:0]  cfg_mask,
  input  logic        cfg_range,
  input  logic        cfg_coding,
  input  logic        req_vld,
  input  logic [2:0]  req_ch,
  output logic        req_rdy,
  output logic        fe_start,
  output logic [15:0] fe_word,
  input  logic        fe_done,
  input  logic [15:0] fe_rdata,
  output logic        res_vld,
  output logic [2:0]  res_ch,
  output logic [11:0] res_data,
  output logic        res_oneshot,
  output logic        res_err,
  output logic        busy
);

  localparam int CW = $clog2(SAMPLE_PERIOD);

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic        tick;
  logic [15:0] word_q, word_d;
  tag_t        cur_q, cur_d;
  tag_t        prev_q, prev_d;
  logic [2:0]  last_q, last_d;
  logic [7:0]  pwr_q, pwr_d;
  logic        pwrup_pending;
  logic        scan_found;
  logic [2:0]  scan_ch;
  logic        emit;
  logic        unused_rdata_msb;

  logic        res_vld_q;
  logic [2:0]  res_ch_q;
  logic [11:0] res_data_q;
  logic        res_os_q;
  logic        res_err_q;

  assign unused_rdata_msb = fe_rdata[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick          = (cnt_q == CW'(SAMPLE_PERIOD - 1));
  assign pwrup_pending = (pwr_q != 8'd0);
  assign req_rdy       = (state_q == ST_WAIT) & tick & !pwrup_pending;

  ad7928_rr_pick u_pick (
    .mask_i  (cfg_mask),
    .ptr_i   (last_q),
    .found_o (scan_found),
    .sel_o   (scan_ch)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    last_d  = last_q;
    pwr_d   = pwr_q;
    unique case (state_q)
      ST_PWRUP: begin
        if (!pwrup_pending) begin
          state_d = ST_WAIT;
        end else if (tick) begin
          word_d  = DUMMY_WORD;
          cur_d   = '0;
          pwr_d   = pwr_q - 8'd1;
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (tick) begin
          state_d = ST_ISSUE;
          if (req_rdy && req_vld) begin
            word_d = ctrl_word(req_ch, cfg_range, cfg_coding);
            cur_d  = '{vld: 1'b1, ch: req_ch, oneshot: 1'b1};
          end else if (cfg_en && scan_found) begin
            word_d = ctrl_word(scan_ch, cfg_range, cfg_coding);
            cur_d  = '{vld: 1'b1, ch: scan_ch, oneshot: 1'b0};
            last_d = scan_ch;
          end else if (prev_q.vld) begin
            // Flush: WRITE=0 leaves the ADC register alone
            word_d = FLUSH_WORD;
            cur_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (fe_done) begin
          prev_d  = cur_q;
          state_d = pwrup_pending ? ST_PWRUP : ST_WAIT;
        end
      end
      ST_IDLE: begin
        if (req_vld || (cfg_en && (cfg_mask != 8'd0))) begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_PWRUP;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PWRUP;
      word_q  <= DUMMY_WORD;
      cur_q   <= '0;
      prev_q  <= '0;
      last_q  <= 3'd7;
      pwr_q   <= 8'(PWRUP_FRAMES);
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      last_q  <= last_d;
      pwr_q   <= pwr_d;
    end
  end

  // Data in this frame belongs to the tag of the previous frame
  assign emit = (state_q == ST_WAIT_DONE) & fe_done & prev_q.vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_vld_q  <= 1'b0;
      res_ch_q   <= '0;
      res_data_q <= '0;
      res_os_q   <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      res_vld_q <= emit;
      if (emit) begin
        res_ch_q   <= prev_q.ch;
        res_data_q <= fe_rdata[11:0];
        res_os_q   <= prev_q.oneshot;
        res_err_q  <= (fe_rdata[14:12] != prev_q.ch);
      end
    end
  end

  assign fe_start    = (state_q == ST_ISSUE);
  assign fe_word     = word_q;
  assign res_vld     = res_vld_q;
  assign res_ch      = res_ch_q;
  assign res_data    = res_data_q;
  assign res_oneshot = res_os_q;
  assign res_err     = res_err_q;
  assign busy        = (state_q != ST_IDLE) | prev_q.vld | res_vld_q;

endmodule

// File: tb/tb_ad7928_sched.sv
// Directed bench for ad7928_sched with a behavioural
// frame engine / ADC model returning data one frame late.
module tb_ad7928_sched;

  localparam int FE_LAT = 20;

  logic        clk;
  logic        rst_n;
  logic        cfg_en;
  logic [7:0]  cfg_mask;
  logic        cfg_range;
  logic        cfg_coding;
  logic        req_vld;
  logic [2:0]  req_ch;
  logic        req_rdy;
  logic        fe_start;
  logic [15:0] fe_word;
  logic        fe_done;
  logic [15:0] fe_rdata;
  logic        res_vld;
  logic [2:0]  res_ch;
  logic [11:0] res_data;
  logic        res_oneshot;
  logic        res_err;
  logic        busy;

  int ntests = 0;
  int nfail  = 0;

  logic        corrupt;
  logic [2:0]  adc_addr;
  logic [15:0] frames[$];
  logic [2:0]  rch[$];
  logic [11:0] rdat[$];
  logic        ros[$];
  logic        rerr[$];

  ad7928_sched #(
    .SAMPLE_PERIOD (50),
    .PWRUP_FRAMES  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_en      (cfg_en),
    .cfg_mask    (cfg_mask),
    .cfg_range   (cfg_range),
    .cfg_coding  (cfg_coding),
    .req_vld     (req_vld),
    .req_ch      (req_ch),
    .req_rdy     (req_rdy),
    .fe_start    (fe_start),
    .fe_word     (fe_word),
    .fe_done     (fe_done),
    .fe_rdata    (fe_rdata),
    .res_vld     (res_vld),
    .res_ch      (res_ch),
    .res_data    (res_data),
    .res_oneshot (res_oneshot),
    .res_err     (res_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Frame engine + ADC: returns result of previously addressed channel
  initial begin
    logic [15:0] w;
    logic        ab;
    fe_done  = 1'b0;
    fe_rdata = '0;
    adc_addr = 3'd7;
    forever begin
      @(negedge clk);
      if (rst_n && fe_start) begin
        w  = fe_word;
        ab = 1'b0;
        frames.push_back(w);
        for (int k = 0; k < FE_LAT; k++) begin
          @(negedge clk);
          if (!rst_n) ab = 1'b1;
        end
        if (!ab) begin
          fe_rdata = {1'b0, adc_addr ^ (corrupt ? 3'd1 : 3'd0),
                      12'hA50 | {9'd0, adc_addr}};
          fe_done  = 1'b1;
          @(negedge clk);
          fe_done  = 1'b0;
          if (w[15]) adc_addr = w[12:10];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && res_vld) begin
      rch.push_back(res_ch);
      rdat.push_back(res_data);
      ros.push_back(res_oneshot);
      rerr.push_back(res_err);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    int t = 0;
    while (frames.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_frames", 32'(frames.size() >= n), 32'd1);
  endtask

  task automatic wait_results(input int n);
    int t = 0;
    while (rch.size() < n && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_results", 32'(rch.size() >= n), 32'd1);
  endtask

  task automatic clear_logs();
    frames.delete();
    rch.delete();
    rdat.delete();
    ros.delete();
    rerr.delete();
  endtask

  task automatic do_reset(input logic en, input logic [7:0] m,
                          input logic rg, input logic cd);
    rst_n   = 1'b0;
    req_vld = 1'b0;
    corrupt = 1'b0;
    repeat (3) @(negedge clk);
    clear_logs();
    cfg_en     = en;
    cfg_mask   = m;
    cfg_range  = rg;
    cfg_coding = cd;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int acc;
    int n;
    rst_n      = 1'b1;
    cfg_en     = 1'b1;
    cfg_mask   = 8'hFF;
    cfg_range  = 1'b0;
    cfg_coding = 1'b0;
    req_vld    = 1'b0;
    req_ch     = 3'd0;
    corrupt    = 1'b0;
    #1 rst_n = 1'b0;
    #4;
    chk("rst_fe_start", 32'(fe_start), 32'd0);
    chk("rst_fe_word", 32'(fe_word), 32'hFFFF);
    chk("rst_req_rdy", 32'(req_rdy), 32'd0);
    chk("rst_res_vld", 32'(res_vld), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Full scan: dummies, then ch 0..7 and wrap to 0
    do_reset(1'b1, 8'hFF, 1'b0, 1'b0);
    wait_frames(4);
    chk("no_res_in_pwrup", 32'(rch.size()), 32'd0);
    wait_frames(11);
    chk("dummy0", 32'(frames[0]), 32'hFFFF);
    chk("dummy1", 32'(frames[1]), 32'hFFFF);
    for (int i = 0; i < 9; i++)
      chk("scan_word", 32'(frames[2+i]), 32'h8300 + 32'(i % 8) * 32'h400);
    wait_results(8);
    for (int i = 0; i < 8; i++) begin
      chk("scan_res_ch", 32'(rch[i]), 32'(i));
      chk("scan_res_data", 32'(rdat[i]), 32'hA50 + 32'(i));
      chk("scan_res_err", 32'(rerr[i]), 32'd0);
      chk("scan_res_os", 32'(ros[i]), 32'd0);
    end

    // Sparse mask, RANGE and CODING set
    do_reset(1'b1, 8'b1010_0100, 1'b1, 1'b1);
    wait_frames(7);
    chk("sparse_w2", 32'(frames[2]), 32'h8B30);
    chk("sparse_w3", 32'(frames[3]), 32'h9730);
    chk("sparse_w4", 32'(frames[4]), 32'h9F30);
    chk("sparse_w5", 32'(frames[5]), 32'h8B30);
    chk("sparse_w6", 32'(frames[6]), 32'h9730);

    // One-shot ch6 preempting scan of mask 0x03
    do_reset(1'b1, 8'h03, 1'b0, 1'b0);
    wait_frames(4);
    req_ch  = 3'd6;
    req_vld = 1'b1;
    acc     = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_rdy === 1'b1) begin
        acc = frames.size();
        @(posedge clk);
        #1;
        break;
      end
    end
    req_vld = 1'b0;
    chk("req_accept_at", 32'(acc), 32'd4);
    wait_frames(7);
    chk("os_w2", 32'(frames[2]), 32'h8300);
    chk("os_w3", 32'(frames[3]), 32'h8700);
    chk("os_w4", 32'(frames[4]), 32'h9B00);
    chk("os_w5", 32'(frames[5]), 32'h8300);
    chk("os_w6", 32'(frames[6]), 32'h8700);
    wait_results(4);
    chk("os_r0_ch", 32'(rch[0]), 32'd0);
    chk("os_r1_ch", 32'(rch[1]), 32'd1);
    chk("os_r2_ch", 32'(rch[2]), 32'd6);
    chk("os_r2_os", 32'(ros[2]), 32'd1);
    chk("os_r2_data", 32'(rdat[2]), 32'hA56);
    chk("os_r3_ch", 32'(rch[3]), 32'd0);
    chk("os_r3_os", 32'(ros[3]), 32'd0);

    // Scan disabled after a ch3 frame: flush, result, idle
    do_reset(1'b1, 8'h08, 1'b0, 1'b0);
    wait_frames(3);
    cfg_en = 1'b0;
    chk("fl_w2", 32'(frames[2]), 32'h8F00);
    wait_frames(4);
    chk("fl_flush", 32'(frames[3]), 32'h0000);
    wait_results(1);
    chk("fl_res_ch", 32'(rch[0]), 32'd3);
    chk("fl_res_data", 32'(rdat[0]), 32'hA53);
    repeat (150) @(negedge clk);
    chk("fl_busy", 32'(busy), 32'd0);
    chk("fl_nframes", 32'(frames.size()), 32'd4);
    chk("fl_nres", 32'(rch.size()), 32'd1);

    // Wrong address bits returned by the ADC
    do_reset(1'b1, 8'hFF, 1'b0, 1'b0);
    corrupt = 1'b1;
    wait_results(2);
    chk("err_r0_err", 32'(rerr[0]), 32'd1);
    chk("err_r0_ch", 32'(rch[0]), 32'd0);
    chk("err_r0_data", 32'(rdat[0]), 32'hA50);
    chk("err_r1_err", 32'(rerr[1]), 32'd1);
    chk("err_r1_data", 32'(rdat[1]), 32'hA51);

    // Asynchronous reset in the middle of a frame
    n = frames.size();
    wait_frames(n + 1);
    repeat (5) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_fe_start", 32'(fe_start), 32'd0);
    chk("mid_fe_word", 32'(fe_word), 32'hFFFF);
    chk("mid_req_rdy", 32'(req_rdy), 32'd0);
    chk("mid_res_vld", 32'(res_vld), 32'd0);
    chk("mid_res_ch", 32'(res_ch), 32'd0);
    chk("mid_res_data", 32'(res_data), 32'd0);
    chk("mid_res_err", 32'(res_err), 32'd0);
    chk("mid_busy", 32'(busy), 32'd1);
    corrupt = 1'b0;
    repeat (3) @(negedge clk);
    clear_logs();
    @(negedge clk);
    rst_n = 1'b1;
    wait_frames(3);
    chk("rr_dummy0", 32'(frames[0]), 32'hFFFF);
    chk("rr_dummy1", 32'(frames[1]), 32'hFFFF);
    chk("rr_w2", 32'(frames[2]), 32'h8300);
    wait_results(1);
    chk("rr_r0_ch", 32'(rch[0]), 32'd0);
    chk("rr_r0_err", 32'(rerr[0]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/ad7928_sched.md
# ad7928_sched

Conversion scheduler for the AD7928 8-channel ADC. It decides which channel each serial frame addresses: round-robin over an enabled-channel mask, with one-shot priority requests allowed to preempt. It drives the SPI frame engine through a start/done handshake, handles the power-up dummy frames, and re-aligns the ADC's one-frame result pipeline. Results leave as tagged 12-bit samples to downstream filtering/readout logic.

## Interface
- SAMPLE_PERIOD, 50: clocks between frame-start opportunities (1 MHz at 50 MHz clk); min 2.
- PWRUP_FRAMES, 2: dummy frames issued after reset.
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_en  in  1  continuous scan enable.
- cfg_mask  in  8  scan channel enable, bit i = channel i.
- cfg_range  in  1  RANGE bit of control word.
- cfg_coding  in  1  CODING bit of control word.
- req_vld  in  1  one-shot conversion request.
- req_ch  in  3  requested channel.
- req_rdy  out  1  request accepted when req_vld & req_rdy.
- fe_start  out  1  one-cycle frame-start pulse to frame engine.
- fe_word  out  16  control word to shift out on DIN, MSB first.
- fe_done  in  1  one-cycle pulse: frame finished, fe_rdata valid.
- fe_rdata  in  16  word shifted in on DOUT: {0, ADD[2:0], DATA[11:0]}.
- res_vld  out  1  result strobe, one cycle.
- res_ch  out  3  channel the result belongs to.
- res_data  out  12  conversion result.
- res_oneshot  out  1  result came from a one-shot request.
- res_err  out  1  returned address bits differ from res_ch.
- busy  out  1  not in IDLE, or a result is still pending.

## Operation
- States: PWRUP, WAIT, ISSUE, WAIT_DONE, IDLE.
- tick: free-running counter 0..SAMPLE_PERIOD-1, cleared by reset; tick = counter at SAMPLE_PERIOD-1.
- PWRUP: issues PWRUP_FRAMES frames with fe_word = 16'hFFFF, one per tick. Their results are discarded. Then goes to WAIT.
- WAIT: on tick, selects the next frame source:
  - first, an accepted one-shot request;
  - else, if cfg_en, the next set bit of cfg_mask strictly after last_ch, wrapping 7 to 0;
  - else, if a result is pending, a flush frame;
  - else, IDLE.
- If cfg_en = 1 but cfg_mask = 0, the scan selects nothing and behaves as if cfg_en = 0.
- Control word: {1, 0 (SEQ), 0, ch[2:0], 2'b11 (PM normal), 0 (SHADOW), 0, cfg_range, cfg_coding, 4'b0000}.
- Flush word: 16'h0000. WRITE = 0, so the ADC control register is untouched. A flush frame carries an invalid tag.
- Pipeline: the data returned in frame N belongs to the channel addressed in frame N-1.
  - Tag registers: cur = {vld, ch, oneshot} for the frame in flight, prev = the frame before it.
  - On fe_done: if prev.vld, emit a result with prev's tag; then prev <= cur.
- last_ch updates only on scan frames; one-shots do not disturb the round-robin position.
- res_err = (fe_rdata[14:12] != prev.ch). The sample is still emitted; bit 15 is ignored.
- IDLE: leaves when req_vld or cfg_en with a nonzero mask is seen, then waits in WAIT for the next tick.
- cfg_* are sampled at the selection cycle; changes apply to the next frame only.

## Timing
- Reset values:
  - fe_start = 0, fe_word = 16'hFFFF, req_rdy = 0;
  - res_* all 0, busy = 1;
  - state PWRUP, tags invalid, last_ch = 7 (so the scan starts at channel 0).
- req_rdy = (state == WAIT) & tick & !pwrup_pending; combinational from registers.
- WAIT→ISSUE on tick. ISSUE asserts fe_start for one cycle with fe_word registered the same cycle; fe_word holds until fe_done.
- ISSUE→WAIT_DONE. On fe_done, returns to WAIT.
- A tick coincident with fe_done is missed; the next frame starts at the following tick. If a frame runs longer than SAMPLE_PERIOD, the frame rate drops; no error is raised.
- res_vld fires one cycle after fe_done (registered).
- Latency from request acceptance to result: two frames plus 1 clk.
- An asynchronous reset mid-frame returns the block to PWRUP; pending results are dropped. The frame engine shares rst_n.

## Structure
- Package ad7928_pkg:
  - control word bit positions, PM_NORMAL = 2'b11, DUMMY_WORD = 16'hFFFF, FLUSH_WORD = 16'h0000;
  - state enum;
  - tag struct {vld, ch[2:0], oneshot}.
- One sub-module, ad7928_rr_pick: combinational next set bit after a pointer, with an 8-bit mask input and a found flag.
- The frame engine is a separate peer block, not instantiated here.

## Test plan
- Reset, cfg_en = 1, mask = 8'hFF, frame engine model returns {0, addr, 12'hA5x}:
  - two 16'hFFFF frames appear, with no res_vld;
  - then words address ch 0,1,…,7,0;
  - results for ch 0..7 appear in order with res_err = 0.
- mask = 8'b1010_0100: frames address 2,5,7,2,5…
- req_vld with req_ch = 6 during a scan of mask 8'h03:
  - accepted on the next tick;
  - frame order 0,1,6,0 (the round-robin position is not disturbed);
  - ch6 result has res_oneshot = 1.
- cfg_en dropped after a ch3 frame: one 16'h0000 flush frame follows, the ch3 result is emitted, then IDLE with busy = 0.
- Model returns the wrong address bits: res_vld with res_err = 1, data passed through unchanged.
- Reset asserted mid-frame: all outputs go to reset values immediately, and PWRUP dummy frames repeat afterwards.
